// File: rtl/exception_vector_unit.sv
// Exception sequencer: saves EPC/cause, presents the cause's vector address to the
// IorD mux, fetches the handler address from memory and strobes it into PC.
module exception_vector_unit #(
    parameter logic [31:0] VEC_OPCODE = 32'd253,
    parameter logic [31:0] VEC_OVF    = 32'd254,
    parameter logic [31:0] VEC_DIV0   = 32'd255,
    parameter int unsigned MEM_LAT    = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_div0,
    input  logic [31:0] PC_in,
    input  logic [31:0] mem_data_in,
    output logic [31:0] Expction_out,
    output logic        iord_req,
    output logic [31:0] EPC_out,
    output logic [1:0]  cause_out,
    output logic [31:0] handler_pc,
    output logic        pc_load,
    output logic        busy,
    output logic        exc_dropped
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADDR = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;
    localparam logic [1:0] LOAD = 2'd3;

    localparam logic [2:0] WAIT_INIT = 3'(MEM_LAT - 1);

    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [31:0] vec_q, vec_d;
    logic [31:0] epc_q, epc_d;
    logic [1:0]  cause_q, cause_d;
    logic [31:0] hpc_q, hpc_d;
    logic        iord_q, iord_d;
    logic        pcl_q, pcl_d;
    logic        busy_q, busy_d;
    logic        drop_q, drop_d;
    logic        any_flag;

    // Only the low byte of the vector entry carries the handler address.
    logic unused_mem_hi;
    assign unused_mem_hi = ^mem_data_in[31:8];

    assign any_flag = exc_opcode | exc_overflow | exc_div0;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        epc_d   = epc_q;
        cause_d = cause_q;
        hpc_d   = hpc_q;
        iord_d  = iord_q;
        pcl_d   = 1'b0;
        drop_d  = drop_q | ((state_q != IDLE) & any_flag);
        case (state_q)
            IDLE: begin
                if (any_flag) begin
                    epc_d   = PC_in - 32'd4;
                    state_d = ADDR;
                    if (exc_opcode) begin
                        cause_d = 2'b01;
                        vec_d   = VEC_OPCODE;
                    end else if (exc_overflow) begin
                        cause_d = 2'b10;
                        vec_d   = VEC_OVF;
                    end else begin
                        cause_d = 2'b11;
                        vec_d   = VEC_DIV0;
                    end
                end
            end
            ADDR: begin
                iord_d  = 1'b1;
                cnt_d   = WAIT_INIT;
                state_d = WAIT;
            end
            WAIT: begin
                if (cnt_q == 3'd0) begin
                    hpc_d   = {24'b0, mem_data_in[7:0]};
                    iord_d  = 1'b0;
                    state_d = LOAD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            LOAD: begin
                pcl_d   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            cnt_q   <= 3'd0;
            vec_q   <= 32'd0;
            epc_q   <= 32'd0;
            cause_q <= 2'b00;
            hpc_q   <= 32'd0;
            iord_q  <= 1'b0;
            pcl_q   <= 1'b0;
            busy_q  <= 1'b0;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
            hpc_q   <= hpc_d;
            iord_q  <= iord_d;
            pcl_q   <= pcl_d;
            busy_q  <= busy_d;
            drop_q  <= drop_d;
        end
    end

    assign Expction_out = vec_q;
    assign EPC_out      = epc_q;
    assign cause_out    = cause_q;
    assign handler_pc   = hpc_q;
    assign iord_req     = iord_q;
    assign pc_load      = pcl_q;
    assign busy         = busy_q;
    assign exc_dropped  = drop_q;

endmodule

// File: tb/tb_exception_vector_unit.sv
// Bench for exception_vector_unit: two instances (MEM_LAT=1 and MEM_LAT=4) driven in
// parallel and compared against a timeline model built from the accept edge of each exception.
module tb_exception_vector_unit;

    logic        clk;
    logic        reset_n;
    logic        exc_opcode, exc_overflow, exc_div0;
    logic [31:0] pc_in, mem_data_in;

    logic [31:0] o_exc   [2];
    logic [31:0] o_epc   [2];
    logic [1:0]  o_cause [2];
    logic [31:0] o_hpc   [2];
    logic        o_iord  [2];
    logic        o_pcl   [2];
    logic        o_busy  [2];
    logic        o_drop  [2];

    int n_checks = 0;
    int n_pass   = 0;
    int ecnt     = 0;

    // Reference model: one accepted exception per instance, tracked by its edge index.
    bit          m_active [2];
    int          m_start  [2];
    logic [31:0] m_epc    [2];
    logic [31:0] m_vec    [2];
    logic [31:0] m_hpc    [2];
    logic [1:0]  m_cause  [2];
    bit          m_drop   [2];

    int first_pcl [2];
    int n_pcl     [2];
    int n_iord    [2];
    int n_iord_ok [2];

    exception_vector_unit #(.MEM_LAT(1)) dut1 (
        .clk(clk), .reset_n(reset_n),
        .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
        .PC_in(pc_in), .mem_data_in(mem_data_in),
        .Expction_out(o_exc[0]), .iord_req(o_iord[0]), .EPC_out(o_epc[0]),
        .cause_out(o_cause[0]), .handler_pc(o_hpc[0]), .pc_load(o_pcl[0]),
        .busy(o_busy[0]), .exc_dropped(o_drop[0])
    );

    exception_vector_unit #(.MEM_LAT(4)) dut4 (
        .clk(clk), .reset_n(reset_n),
        .exc_opcode(exc_opcode), .exc_overflow(exc_overflow), .exc_div0(exc_div0),
        .PC_in(pc_in), .mem_data_in(mem_data_in),
        .Expction_out(o_exc[1]), .iord_req(o_iord[1]), .EPC_out(o_epc[1]),
        .cause_out(o_cause[1]), .handler_pc(o_hpc[1]), .pc_load(o_pcl[1]),
        .busy(o_busy[1]), .exc_dropped(o_drop[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int lat_of(int k);
        return (k == 0) ? 1 : 4;
    endfunction

    function automatic logic exp_iord(int k);
        return m_active[k] && (ecnt >= m_start[k] + 1) && (ecnt <= m_start[k] + lat_of(k));
    endfunction

    function automatic logic exp_pcl(int k);
        return m_active[k] && (ecnt == m_start[k] + 2 + lat_of(k));
    endfunction

    function automatic logic exp_busy(int k);
        return m_active[k] && (ecnt < m_start[k] + 2 + lat_of(k));
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_active[k] = 0;
            m_start[k]  = 0;
            m_epc[k]    = 32'd0;
            m_vec[k]    = 32'd0;
            m_hpc[k]    = 32'd0;
            m_cause[k]  = 2'b00;
            m_drop[k]   = 0;
        end
    endtask

    // Advance one clock edge, update the model from the inputs seen at that edge.
    task automatic step();
        bit in_seq;
        @(posedge clk);
        ecnt++;
        for (int k = 0; k < 2; k++) begin
            in_seq = m_active[k] && (ecnt <= m_start[k] + 2 + lat_of(k));
            if (m_active[k] && ecnt == m_start[k] + 1 + lat_of(k))
                m_hpc[k] = {24'b0, mem_data_in[7:0]};
            if (exc_opcode || exc_overflow || exc_div0) begin
                if (in_seq) begin
                    m_drop[k] = 1;
                end else begin
                    m_active[k] = 1;
                    m_start[k]  = ecnt;
                    m_epc[k]    = pc_in - 32'd4;
                    if (exc_opcode) begin
                        m_cause[k] = 2'b01; m_vec[k] = 32'd253;
                    end else if (exc_overflow) begin
                        m_cause[k] = 2'b10; m_vec[k] = 32'd254;
                    end else begin
                        m_cause[k] = 2'b11; m_vec[k] = 32'd255;
                    end
                end
            end
        end
        @(negedge clk);
    endtask

    // Step n cycles with flags low, recording pc_load/iord_req timing per instance.
    task automatic measure(int n);
        for (int k = 0; k < 2; k++) begin
            first_pcl[k] = -1; n_pcl[k] = 0; n_iord[k] = 0; n_iord_ok[k] = 0;
        end
        for (int c = 1; c <= n; c++) begin
            step();
            exc_opcode = 0; exc_overflow = 0; exc_div0 = 0;
            for (int k = 0; k < 2; k++) begin
                if (o_pcl[k]) begin
                    n_pcl[k]++;
                    if (first_pcl[k] < 0) first_pcl[k] = c;
                end
                if (o_iord[k]) begin
                    n_iord[k]++;
                    if (o_exc[k] == m_vec[k]) n_iord_ok[k]++;
                end
            end
        end
    endtask

    task automatic do_reset();
        exc_opcode = 0; exc_overflow = 0; exc_div0 = 0;
        pc_in = 32'd0; mem_data_in = 32'd0;
        #2 reset_n = 1'b0;
        model_clear();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        exc_opcode = 0; exc_overflow = 0; exc_div0 = 0;
        #2 reset_n = 1'b0;
        model_clear();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({o_exc[k], o_epc[k], o_cause[k], o_hpc[k], o_iord[k], o_pcl[k], o_busy[k],
                 o_drop[k]} !== 102'd0)
                $display("FAIL reset_state dut%0d: got exc=%h epc=%h cause=%b hpc=%h flags=%b%b%b%b expected all zero",
                         k, o_exc[k], o_epc[k], o_cause[k], o_hpc[k], o_iord[k], o_pcl[k],
                         o_busy[k], o_drop[k]);
            else n_pass++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        step();
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({o_busy[k], o_iord[k], o_pcl[k]} !== 3'b000)
                $display("FAIL idle_after_reset dut%0d: got busy/iord/pcl=%b expected 000",
                         k, {o_busy[k], o_iord[k], o_pcl[k]});
            else n_pass++;
        end
    endtask

    task automatic test_overflow();
        do_reset();
        pc_in = 32'h0000_0044; mem_data_in = 32'h0000_00A0; exc_overflow = 1;
        step();
        exc_overflow = 0;
        n_checks++;
        if ({o_epc[0], o_cause[0], o_exc[0], o_busy[0]} !== {32'h40, 2'b10, 32'd254, 1'b1})
            $display("FAIL ovf_record: got epc=%h cause=%b vec=%0d busy=%b expected epc=40 cause=10 vec=254 busy=1",
                     o_epc[0], o_cause[0], o_exc[0], o_busy[0]);
        else n_pass++;
        measure(8);
        n_checks++;
        if (first_pcl[0] !== 3 || n_pcl[0] !== 1)
            $display("FAIL ovf_pc_load: got first=%0d count=%0d expected first=3 count=1",
                     first_pcl[0], n_pcl[0]);
        else n_pass++;
        n_checks++;
        if (n_iord[0] !== 1 || n_iord_ok[0] !== 1)
            $display("FAIL ovf_iord: got cycles=%0d with_vec=%0d expected 1 and 1",
                     n_iord[0], n_iord_ok[0]);
        else n_pass++;
        n_checks++;
        if (o_hpc[0] !== 32'hA0)
            $display("FAIL ovf_handler: got %h expected 000000a0", o_hpc[0]);
        else n_pass++;
    endtask

    task automatic test_latency();
        do_reset();
        pc_in = 32'h0000_1000; mem_data_in = 32'hFFFF_FF3C; exc_div0 = 1;
        step();
        exc_div0 = 0;
        measure(10);
        n_checks++;
        if (first_pcl[1] !== 6 || n_pcl[1] !== 1)
            $display("FAIL lat4_pc_load: got first=%0d count=%0d expected first=6 count=1",
                     first_pcl[1], n_pcl[1]);
        else n_pass++;
        n_checks++;
        if (n_iord[1] !== 4 || n_iord_ok[1] !== 4)
            $display("FAIL lat4_iord: got cycles=%0d with_vec=%0d expected 4 and 4",
                     n_iord[1], n_iord_ok[1]);
        else n_pass++;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_hpc[k] !== 32'h3C || o_exc[k] !== 32'd255)
                $display("FAIL lat_handler dut%0d: got hpc=%h vec=%0d expected 0000003c 255",
                         k, o_hpc[k], o_exc[k]);
            else n_pass++;
        end
    endtask

    task automatic test_priority();
        do_reset();
        pc_in = 32'h0000_0100; exc_opcode = 1; exc_div0 = 1;
        step();
        exc_opcode = 0; exc_div0 = 0;
        n_checks++;
        if ({o_cause[0], o_exc[0], o_epc[0]} !== {2'b01, 32'd253, 32'hFC})
            $display("FAIL priority: got cause=%b vec=%0d epc=%h expected 01 253 000000fc",
                     o_cause[0], o_exc[0], o_epc[0]);
        else n_pass++;
        measure(10);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (o_drop[k] !== 1'b0)
                $display("FAIL priority_nodrop dut%0d: got %b expected 0", k, o_drop[k]);
            else n_pass++;
        end
    endtask

    task automatic test_drop();
        do_reset();
        pc_in = 32'h0000_0200; mem_data_in = 32'h0000_0055; exc_overflow = 1;
        step();
        exc_overflow = 0; pc_in = 32'h0000_0900;
        step();
        exc_div0 = 1;
        step();
        exc_div0 = 0;
        measure(8);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({o_cause[k], o_epc[k], o_drop[k], o_hpc[k]} !== {2'b10, 32'h1FC, 1'b1, 32'h55})
                $display("FAIL drop dut%0d: got cause=%b epc=%h drop=%b hpc=%h expected 10 000001fc 1 00000055",
                         k, o_cause[k], o_epc[k], o_drop[k], o_hpc[k]);
            else n_pass++;
            n_checks++;
            if (n_pcl[k] !== 1)
                $display("FAIL drop_pc_load dut%0d: got %0d pulses expected 1", k, n_pcl[k]);
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        do_reset();
        pc_in = 32'd0; exc_opcode = 1;
        step();
        exc_opcode = 0;
        n_checks++;
        if ({o_epc[0], o_cause[0]} !== {32'hFFFF_FFFC, 2'b01})
            $display("FAIL epc_wrap: got epc=%h cause=%b expected fffffffc 01",
                     o_epc[0], o_cause[0]);
        else n_pass++;
        measure(8);
    endtask

    task automatic test_mid_reset();
        do_reset();
        pc_in = 32'h0000_0080; mem_data_in = 32'h0000_0077; exc_div0 = 1;
        step();
        exc_div0 = 0;
        step();
        #2 reset_n = 1'b0;
        model_clear();
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({o_exc[k], o_epc[k], o_cause[k], o_hpc[k], o_iord[k], o_pcl[k], o_busy[k],
                 o_drop[k]} !== 102'd0)
                $display("FAIL mid_reset_clear dut%0d: got exc=%h epc=%h cause=%b busy=%b iord=%b expected all zero",
                         k, o_exc[k], o_epc[k], o_cause[k], o_busy[k], o_iord[k]);
            else n_pass++;
        end
        @(negedge clk);
        reset_n = 1'b1;
        measure(8);
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if (n_pcl[k] !== 0 || n_iord[k] !== 0)
                $display("FAIL mid_reset_quiet dut%0d: got pcl=%0d iord=%0d expected 0 0",
                         k, n_pcl[k], n_iord[k]);
            else n_pass++;
        end
    endtask

    task automatic compare_all(string name, int cyc);
        logic [101:0] got, exp;
        for (int k = 0; k < 2; k++) begin
            got = {o_exc[k], o_epc[k], o_cause[k], o_hpc[k], o_iord[k], o_pcl[k], o_busy[k],
                   o_drop[k]};
            exp = {m_vec[k], m_epc[k], m_cause[k], m_hpc[k], exp_iord(k), exp_pcl(k),
                   exp_busy(k), 1'(m_drop[k])};
            n_checks++;
            if (got !== exp)
                $display("FAIL %s dut%0d cycle %0d: got %h expected %h", name, k, cyc, got, exp);
            else n_pass++;
        end
    endtask

    // Flags held high across completion: each return to IDLE retriggers.
    task automatic test_back_to_back();
        do_reset();
        for (int c = 0; c < 24; c++) begin
            exc_overflow = (c < 16);
            exc_opcode   = (c >= 8 && c < 12);
            pc_in        = $urandom;
            mem_data_in  = $urandom;
            step();
            compare_all("back_to_back", c);
        end
        exc_overflow = 0; exc_opcode = 0;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            exc_opcode   = ($urandom_range(0, 9) == 0);
            exc_overflow = ($urandom_range(0, 7) == 0);
            exc_div0     = ($urandom_range(0, 7) == 0);
            pc_in        = $urandom;
            mem_data_in  = $urandom;
            step();
            compare_all("random", c);
        end
        exc_opcode = 0; exc_overflow = 0; exc_div0 = 0;
    endtask

    initial begin
        reset_n = 1'b0;
        exc_opcode = 0; exc_overflow = 0; exc_div0 = 0;
        pc_in = 32'd0; mem_data_in = 32'd0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_overflow();
        test_latency();
        test_priority();
        test_drop();
        test_wrap();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
